// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared declarations for the dual-port game-state RAM controller:
//   - state_e      : controller state (array clear in progress / normal run)
//   - calc_nl      : number of write-enable lanes for a given word/lane width
//   - lane_parity  : even-parity bit of one lane (used when BRAM_PARITY_EN is
//                    defined; the lane is zero-extended to 64 bits)
// -----------------------------------------------------------------------------
package bram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int calc_nl(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic logic lane_parity(input logic [63:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/bram_lane_mem.sv
// -----------------------------------------------------------------------------
// bram_lane_mem
// One byte-lane slice of the true dual-port RAM. Both ports may write and read
// every cycle. A port that writes a word returns the data it wrote
// (write-first); a port that only reads gets the word as it was before this
// edge, even if the other port writes it now (read-old).
// Ports:
//   clk, rst_n          clock, async active-low reset (read registers only)
//   we_x, re_x          write / read strobe of port x (a, b)
//   addr_x, wdata_x     address and write data of port x
//   rdata_x             registered read data of port x, holds when re_x = 0
// -----------------------------------------------------------------------------
module bram_lane_mem #(
    parameter int W  = 8,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_a,
    input  logic          re_a,
    input  logic [AW-1:0] addr_a,
    input  logic [W-1:0]  wdata_a,
    output logic [W-1:0]  rdata_a,
    input  logic          we_b,
    input  logic          re_b,
    input  logic [AW-1:0] addr_b,
    input  logic [W-1:0]  wdata_b,
    output logic [W-1:0]  rdata_b
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_a_q;
    logic [W-1:0] rdata_b_q;

    // Storage array: not reset, the controller clears it explicitly.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_q[addr_a] <= wdata_a;
        end
        if (we_b) begin
            mem_q[addr_b] <= wdata_b;
        end
    end

    // Read registers: write-first on own port, read-old across ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= {W{1'b0}};
            rdata_b_q <= {W{1'b0}};
        end else begin
            if (re_a) begin
                rdata_a_q <= we_a ? wdata_a : mem_q[addr_a];
            end
            if (re_b) begin
                rdata_b_q <= we_b ? wdata_b : mem_q[addr_b];
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/bram_dp_ctl.sv
// -----------------------------------------------------------------------------
// bram_dp_ctl
// Parametrised true dual-port RAM controller. Port A serves the CPU data bus,
// port B the sprite/VGA fetch logic. Holds the clear sequencer FSM, write
// collision arbitration (port A wins per lane), optional output register and
// read-valid strobes. Optional feature macro: BRAM_PARITY_EN adds one
// even-parity bit per lane and the parity_err_a / parity_err_b outputs.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             start a full array clear (sampled only in RUN)
//   ready             high in RUN; requests are accepted only while high
//   en_x, we_x        access request, per-lane write enables (0 = read)
//   addr_x, data_x    address, write data
//   q_x, rvalid_x     read data and one-cycle valid strobe per access
//   collision         one-cycle pulse when any port B lane write was dropped
//   parity_err_x      (BRAM_PARITY_EN) lane parity mismatch, with rvalid_x
// -----------------------------------------------------------------------------
module bram_dp_ctl
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int LANE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    output logic                             ready,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            data_a,
    output logic [DATA_WIDTH-1:0]            q_a,
    output logic                             rvalid_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            data_b,
    output logic [DATA_WIDTH-1:0]            q_b,
    output logic                             rvalid_b,
    output logic                             collision
`ifdef BRAM_PARITY_EN
    ,
    output logic                             parity_err_a,
    output logic                             parity_err_b
`endif
);
    localparam int NL = calc_nl(DATA_WIDTH, LANE_WIDTH);
`ifdef BRAM_PARITY_EN
    localparam int PW = LANE_WIDTH + 1;
`else
    localparam int PW = LANE_WIDTH;
`endif
    // Counter value one past the last address: the idle step before RUN.
    localparam logic [ADDR_WIDTH:0] CLR_END = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q;
    logic                  ready_q;
    logic [ADDR_WIDTH:0]   clr_cnt_q;
    logic                  clr_wr_s;
    logic                  acc_a_s;
    logic                  acc_b_s;
    logic                  same_addr_s;
    logic                  drop_s;
    logic [NL-1:0]         wr_a_s;
    logic [NL-1:0]         wr_b_s;
    logic [DATA_WIDTH-1:0] rd_a_s;
    logic [DATA_WIDTH-1:0] rd_b_s;
    logic                  rv1_a_q;
    logic                  rv1_b_q;
    logic                  collision_q;
`ifdef BRAM_PARITY_EN
    logic [NL-1:0]         lane_err_a_s;
    logic [NL-1:0]         lane_err_b_s;
`endif

    // Clear sequencer / ready FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ready_q   <= 1'b0;
            clr_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_END) begin
                        state_q   <= ST_RUN;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
                    end else begin
                        ready_q   <= 1'b0;
                        clr_cnt_q <= clr_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q   <= ST_CLEAR;
                        ready_q   <= 1'b0;
                        clr_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
                    end else begin
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    ready_q   <= 1'b0;
                    clr_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
                end
            endcase
        end
    end

    // Request acceptance and same-address write arbitration (A wins per lane).
    always_comb begin
        clr_wr_s    = (state_q == ST_CLEAR) && (clr_cnt_q != CLR_END);
        acc_a_s     = ready_q & en_a;
        acc_b_s     = ready_q & en_b;
        same_addr_s = (addr_a == addr_b);
        wr_a_s      = acc_a_s ? we_a : {NL{1'b0}};
        if (acc_b_s && same_addr_s) begin
            wr_b_s = we_b & ~wr_a_s;
            drop_s = |(we_b & wr_a_s);
        end else if (acc_b_s) begin
            wr_b_s = we_b;
            drop_s = 1'b0;
        end else begin
            wr_b_s = {NL{1'b0}};
            drop_s = 1'b0;
        end
    end

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [LANE_WIDTH-1:0] din_a_s;
        logic [LANE_WIDTH-1:0] din_b_s;
        logic [PW-1:0]         wd_a_s;
        logic [PW-1:0]         wd_b_s;
        logic [PW-1:0]         mem_wd_a_s;
        logic [PW-1:0]         dout_a_s;
        logic [PW-1:0]         dout_b_s;
        logic [ADDR_WIDTH-1:0] mem_addr_a_s;

        assign din_a_s = data_a[i*LANE_WIDTH +: LANE_WIDTH];
        assign din_b_s = data_b[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef BRAM_PARITY_EN
        assign wd_a_s          = {lane_parity(64'(din_a_s)), din_a_s};
        assign wd_b_s          = {lane_parity(64'(din_b_s)), din_b_s};
        assign lane_err_a_s[i] = ^dout_a_s;
        assign lane_err_b_s[i] = ^dout_b_s;
`else
        assign wd_a_s = din_a_s;
        assign wd_b_s = din_b_s;
`endif
        // The clear sequencer borrows port A; requests are blocked meanwhile.
        assign mem_addr_a_s = clr_wr_s ? clr_cnt_q[ADDR_WIDTH-1:0] : addr_a;
        assign mem_wd_a_s   = clr_wr_s ? {PW{1'b0}} : wd_a_s;

        bram_lane_mem #(
            .W  (PW),
            .AW (ADDR_WIDTH)
        ) u_mem (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_a    (clr_wr_s | wr_a_s[i]),
            .re_a    (acc_a_s),
            .addr_a  (mem_addr_a_s),
            .wdata_a (mem_wd_a_s),
            .rdata_a (dout_a_s),
            .we_b    (wr_b_s[i]),
            .re_b    (acc_b_s),
            .addr_b  (addr_b),
            .wdata_b (wd_b_s),
            .rdata_b (dout_b_s)
        );

        assign rd_a_s[i*LANE_WIDTH +: LANE_WIDTH] = dout_a_s[LANE_WIDTH-1:0];
        assign rd_b_s[i*LANE_WIDTH +: LANE_WIDTH] = dout_b_s[LANE_WIDTH-1:0];
    end

    // First-stage valid strobes and collision pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_a_q     <= 1'b0;
            rv1_b_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            rv1_a_q     <= acc_a_s;
            rv1_b_q     <= acc_b_s;
            collision_q <= drop_s;
        end
    end

    assign ready     = ready_q;
    assign collision = collision_q;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_a_q;
        logic [DATA_WIDTH-1:0] q_b_q;
        logic                  rv2_a_q;
        logic                  rv2_b_q;
`ifdef BRAM_PARITY_EN
        logic                  perr_a_q;
        logic                  perr_b_q;
`endif

        // Extra output stage; data only advances with a valid read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_a_q    <= {DATA_WIDTH{1'b0}};
                q_b_q    <= {DATA_WIDTH{1'b0}};
                rv2_a_q  <= 1'b0;
                rv2_b_q  <= 1'b0;
`ifdef BRAM_PARITY_EN
                perr_a_q <= 1'b0;
                perr_b_q <= 1'b0;
`endif
            end else begin
                rv2_a_q  <= rv1_a_q;
                rv2_b_q  <= rv1_b_q;
                q_a_q    <= rv1_a_q ? rd_a_s : q_a_q;
                q_b_q    <= rv1_b_q ? rd_b_s : q_b_q;
`ifdef BRAM_PARITY_EN
                perr_a_q <= rv1_a_q & (|lane_err_a_s);
                perr_b_q <= rv1_b_q & (|lane_err_b_s);
`endif
            end
        end

        assign q_a      = q_a_q;
        assign q_b      = q_b_q;
        assign rvalid_a = rv2_a_q;
        assign rvalid_b = rv2_b_q;
`ifdef BRAM_PARITY_EN
        assign parity_err_a = perr_a_q;
        assign parity_err_b = perr_b_q;
`endif
    end else begin : g_no_out_reg
        assign q_a      = rd_a_s;
        assign q_b      = rd_b_s;
        assign rvalid_a = rv1_a_q;
        assign rvalid_b = rv1_b_q;
`ifdef BRAM_PARITY_EN
        assign parity_err_a = rv1_a_q & (|lane_err_a_s);
        assign parity_err_b = rv1_b_q & (|lane_err_b_s);
`endif
    end

endmodule

// File: tb/tb_bram_dp_ctl.sv
// -----------------------------------------------------------------------------
// tb_bram_dp_ctl
// Self-checking bench for bram_dp_ctl (ADDR_WIDTH=4, DATA_WIDTH=16,
// LANE_WIDTH=8). Expected values come from a word-array reference model that
// applies the lane-write, port-A-priority and read-old rules directly.
// -----------------------------------------------------------------------------
module tb_bram_dp_ctl;
    localparam int DW      = 16;
    localparam int AW      = 4;
    localparam int LW      = 8;
    localparam int NL      = DW / LW;
    localparam int DEPTH   = 1 << AW;
    localparam int OUT_REG = 0;
    localparam int LAT     = (OUT_REG != 0) ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          ready;
    logic          en_a, en_b;
    logic [NL-1:0] we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] q_a, q_b;
    logic          rvalid_a, rvalid_b;
    logic          collision;
`ifdef BRAM_PARITY_EN
    logic          parity_err_a, parity_err_b;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct {
        logic          va;
        logic [DW-1:0] qa;
        logic          vb;
        logic [DW-1:0] qb;
    } exp_t;

    bram_dp_ctl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .LANE_WIDTH     (LW),
        .OUT_REG        (OUT_REG),
        .CLEAR_ON_RESET (1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .ready     (ready),
        .en_a      (en_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .rvalid_a  (rvalid_a),
        .en_b      (en_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .q_b       (q_b),
        .rvalid_b  (rvalid_b),
        .collision (collision)
`ifdef BRAM_PARITY_EN
        ,
        .parity_err_a (parity_err_a),
        .parity_err_b (parity_err_b)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ea, input logic [NL-1:0] wa, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da, input logic eb, input logic [NL-1:0] wb,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db);
        en_a = ea; we_a = wa; addr_a = aa; data_a = da;
        en_b = eb; we_b = wb; addr_b = ab; data_b = db;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [DW-1:0] lane_mask(input logic [NL-1:0] we);
        logic [DW-1:0] m;
        m = '0;
        for (int l = 0; l < NL; l++) begin
            if (we[l]) m[l*LW +: LW] = {LW{1'b1}};
        end
        return m;
    endfunction

    // Reference model of one accepted cycle: returns read data and collision,
    // and updates ref_mem.
    task automatic model_access(input logic ea, input logic [NL-1:0] wa, input logic [AW-1:0] aa,
                                input logic [DW-1:0] da, input logic eb, input logic [NL-1:0] wb,
                                input logic [AW-1:0] ab, input logic [DW-1:0] db,
                                output logic [DW-1:0] qa, output logic [DW-1:0] qb,
                                output logic col);
        logic [NL-1:0] wa_eff, wb_eff;
        logic [DW-1:0] ma, mb;
        wa_eff = ea ? wa : '0;
        wb_eff = eb ? wb : '0;
        col = 1'b0;
        if (ea && eb && (aa == ab)) begin
            col    = |(wb_eff & wa_eff);
            wb_eff = wb_eff & ~wa_eff;
        end
        ma = lane_mask(wa_eff);
        mb = lane_mask(wb_eff);
        qa = (da & ma) | (ref_mem[aa] & ~ma);
        qb = (db & mb) | (ref_mem[ab] & ~mb);
        if (|wa_eff) ref_mem[aa] = (ref_mem[aa] & ~ma) | (da & ma);
        if (|wb_eff) ref_mem[ab] = (ref_mem[ab] & ~mb) | (db & mb);
    endtask

    // One access, then wait until its results are on the outputs.
    task automatic issue(input logic ea, input logic [NL-1:0] wa, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da, input logic eb, input logic [NL-1:0] wb,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         output logic [DW-1:0] qa, output logic [DW-1:0] qb);
        logic col;
        drive(ea, wa, aa, da, eb, wb, ab, db);
        model_access(ea, wa, aa, da, eb, wb, ab, db, qa, qb, col);
        tick();
        idle();
        for (int k = 1; k < LAT; k++) tick();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        clear = 1'b0;
        idle();
        tick();
        tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
        total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid_a, rvalid_b); end
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b exp=0", collision); end
        total++; if (q_a !== 16'h0000 || q_b !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h/%h exp=0000/0000", q_a, q_b); end
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++; if (n !== 17) begin bad++; $display("FAIL reset_clear_cycles got=%0d exp=17", n); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic test_clear_contents();
        logic [DW-1:0] qa, qb;
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(DEPTH-1-i), '0, qa, qb);
            total++; if (rvalid_a !== 1'b1 || q_a !== 16'h0000) begin bad++; $display("FAIL clear_read_a addr=%0d got=%b/%h exp=1/0000", i, rvalid_a, q_a); end
            total++; if (rvalid_b !== 1'b1 || q_b !== qb) begin bad++; $display("FAIL clear_read_b addr=%0d got=%b/%h exp=1/%h", DEPTH-1-i, rvalid_b, q_b, qb); end
        end
    endtask

    task automatic test_partial_write();
        logic [DW-1:0] qa, qb;
        logic col;
        drive(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, '0, '0, '0);
        model_access(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, '0, '0, '0, qa, qb, col);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) idle();
            total++; if (rvalid_a !== (k == LAT)) begin bad++; $display("FAIL partial_latency cycle=%0d got=%b exp=%b", k, rvalid_a, (k == LAT)); end
        end
        total++; if (q_a !== 16'h0034) begin bad++; $display("FAIL partial_write_q got=%h exp=0034", q_a); end
        tick();
        total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL partial_pulse got=%b exp=0", rvalid_a); end
        issue(1'b1, '0, 4'd3, '0, 1'b0, '0, '0, '0, qa, qb);
        total++; if (q_a !== qa || q_a !== 16'h0034) begin bad++; $display("FAIL partial_readback got=%h exp=%h", q_a, qa); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] qa, qb;
        logic col;
        drive(1'b1, 2'b10, 4'd5, 16'hAAAA, 1'b1, 2'b11, 4'd5, 16'h5555);
        model_access(1'b1, 2'b10, 4'd5, 16'hAAAA, 1'b1, 2'b11, 4'd5, 16'h5555, qa, qb, col);
        tick();
        idle();
        total++; if (collision !== col) begin bad++; $display("FAIL collision_pulse got=%b exp=%b", collision, col); end
        tick();
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL collision_one_cycle got=%b exp=0", collision); end
        issue(1'b1, '0, 4'd5, '0, 1'b0, '0, '0, '0, qa, qb);
        total++; if (q_a !== 16'hAA55) begin bad++; $display("FAIL collision_merge got=%h exp=AA55", q_a); end
        // Disjoint lanes on the same address: nothing dropped.
        drive(1'b1, 2'b01, 4'd6, 16'h1111, 1'b1, 2'b10, 4'd6, 16'h2222);
        model_access(1'b1, 2'b01, 4'd6, 16'h1111, 1'b1, 2'b10, 4'd6, 16'h2222, qa, qb, col);
        tick();
        idle();
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL collision_disjoint got=%b exp=0", collision); end
        for (int k = 1; k < LAT; k++) tick();
        issue(1'b0, '0, '0, '0, 1'b1, '0, 4'd6, '0, qa, qb);
        total++; if (q_b !== 16'h2211) begin bad++; $display("FAIL disjoint_merge got=%h exp=2211", q_b); end
    endtask

    task automatic test_cross_read();
        logic [DW-1:0] qa, qb;
        issue(1'b1, 2'b11, 4'd7, 16'hBEEF, 1'b1, '0, 4'd7, '0, qa, qb);
        total++; if (q_b !== 16'h0000) begin bad++; $display("FAIL cross_read_old got=%h exp=0000", q_b); end
        total++; if (q_a !== 16'hBEEF) begin bad++; $display("FAIL cross_write_first got=%h exp=BEEF", q_a); end
        issue(1'b0, '0, '0, '0, 1'b1, '0, 4'd7, '0, qa, qb);
        total++; if (q_b !== 16'hBEEF) begin bad++; $display("FAIL cross_read_new got=%h exp=BEEF", q_b); end
    endtask

    task automatic test_random();
        exp_t pipe[$];
        exp_t e, f;
        logic col;
        logic ea, eb;
        logic [NL-1:0] wa, wb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;
        for (int c = 0; c < 300 + LAT - 1; c++) begin
            if (c < 300) begin
                ea = ($urandom_range(0, 3) != 0);
                eb = ($urandom_range(0, 3) != 0);
                wa = NL'($urandom_range(0, 3));
                wb = NL'($urandom_range(0, 3));
                aa = AW'($urandom_range(0, 3));
                ab = AW'($urandom_range(0, 3));
                da = DW'($urandom);
                db = DW'($urandom);
            end else begin
                ea = 1'b0; eb = 1'b0; wa = '0; wb = '0; aa = '0; ab = '0; da = '0; db = '0;
            end
            drive(ea, wa, aa, da, eb, wb, ab, db);
            model_access(ea, wa, aa, da, eb, wb, ab, db, e.qa, e.qb, col);
            e.va = ea;
            e.vb = eb;
            pipe.push_back(e);
            tick();
            total++; if (collision !== col) begin bad++; $display("FAIL rand_collision cyc=%0d got=%b exp=%b", c, collision, col); end
            if (pipe.size() == LAT) begin
                f = pipe.pop_front();
                total++; if (rvalid_a !== f.va || rvalid_b !== f.vb) begin bad++; $display("FAIL rand_rvalid cyc=%0d got=%b%b exp=%b%b", c, rvalid_a, rvalid_b, f.va, f.vb); end
                if (f.va) begin
                    total++; if (q_a !== f.qa) begin bad++; $display("FAIL rand_q_a cyc=%0d got=%h exp=%h", c, q_a, f.qa); end
                end
                if (f.vb) begin
                    total++; if (q_b !== f.qb) begin bad++; $display("FAIL rand_q_b cyc=%0d got=%h exp=%h", c, q_b, f.qb); end
                end
            end
        end
        idle();
    endtask

    task automatic test_runtime_clear();
        logic [DW-1:0] qa, qb;
        int n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++; if (n !== 17) begin bad++; $display("FAIL runtime_clear_cycles got=%0d exp=17", n); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, '0, AW'(i), '0, 1'b0, '0, '0, '0, qa, qb);
            total++; if (q_a !== 16'h0000) begin bad++; $display("FAIL runtime_clear_read addr=%0d got=%h exp=0000", i, q_a); end
        end
    endtask

    task automatic test_clear_reset();
        logic [DW-1:0] qa, qb;
        logic [DW-1:0] hold_a;
        int n;
        issue(1'b1, 2'b11, 4'd1, 16'hC0DE, 1'b0, '0, '0, '0, qa, qb);
        hold_a = qa;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL clear_ready_low got=%b exp=0", ready); end
        drive(1'b1, 2'b11, 4'd9, 16'hFFFF, 1'b1, '0, 4'd1, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin bad++; $display("FAIL clear_blocked_rvalid k=%0d got=%b%b exp=00", k, rvalid_a, rvalid_b); end
        end
        total++; if (q_a !== hold_a) begin bad++; $display("FAIL clear_q_hold got=%h exp=%h", q_a, hold_a); end
        idle();
        rst_n = 1'b0;
        tick();
        total++; if (ready !== 1'b0 || q_a !== 16'h0000) begin bad++; $display("FAIL midclear_reset got=%b/%h exp=0/0000", ready, q_a); end
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++; if (n !== 17) begin bad++; $display("FAIL midclear_restart_cycles got=%0d exp=17", n); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        issue(1'b1, '0, 4'd9, '0, 1'b1, '0, 4'd1, '0, qa, qb);
        total++; if (q_a !== 16'h0000 || q_b !== 16'h0000) begin bad++; $display("FAIL midclear_contents got=%h/%h exp=0000/0000", q_a, q_b); end
    endtask

`ifdef BRAM_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] qa, qb;
        issue(1'b1, '0, 4'd2, '0, 1'b0, '0, '0, '0, qa, qb);
        total++; if (parity_err_a !== 1'b0) begin bad++; $display("FAIL parity_clean got=%b exp=0", parity_err_a); end
        u_dut.g_lane[0].u_mem.mem_q[2][0] = ~u_dut.g_lane[0].u_mem.mem_q[2][0];
        issue(1'b1, '0, 4'd2, '0, 1'b0, '0, '0, '0, qa, qb);
        total++; if (parity_err_a !== 1'b1 || rvalid_a !== 1'b1) begin bad++; $display("FAIL parity_err got=%b/%b exp=1/1", parity_err_a, rvalid_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_clear_contents();
        test_partial_write();
        test_collision();
        test_cross_read();
        test_random();
        test_runtime_clear();
        test_clear_reset();
`ifdef BRAM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
